// File: rtl/vcve2_vstore_unit.sv
// Unit-stride vector store engine: reads one vector register word by word from
// the VRF and writes it to data memory over the request/grant/rvalid bus.
module vcve2_vstore_unit #(
  parameter int VLEN = 128,
  localparam int NW = VLEN / 32,
  localparam int KW = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [31:0]   base_addr_i,
  input  logic [2:0]    vsew_i,
  input  logic [7:0]    vl_i,
  input  logic [4:0]    vs3_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          vrf_req_o,
  output logic [4:0]    vrf_raddr_o,
  output logic [KW-1:0] vrf_word_o,
  input  logic          vrf_rvalid_i,
  input  logic [31:0]   vrf_rdata_i,
  output logic          data_req_o,
  output logic [31:0]   data_addr_o,
  output logic          data_we_o,
  output logic [3:0]    data_be_o,
  output logic [31:0]   data_wdata_o,
  input  logic          data_gnt_i,
  input  logic          data_rvalid_i,
  input  logic          data_err_i,
  output logic [2:0]    state_o
);

  localparam logic [2:0] VSEW_8  = 3'd0;
  localparam logic [2:0] VSEW_16 = 3'd1;
  localparam logic [2:0] VSEW_32 = 3'd2;

  // Bus handshake: a request is held with all request fields stable until the
  // cycle data_gnt_i is high; exactly one rvalid (with data_err_i) follows
  // later, and only then may the next request be issued.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    REQ  = 3'd2,
    RESP = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e        state_q;
  logic [KW-1:0] k_q;
  logic [KW-1:0] last_k_q;
  logic [3:0]    last_be_q;
  logic [31:0]   addr_q;

  logic          sew_ok;
  logic [31:0]   vlmax;
  logic [10:0]   nbytes;
  logic [10:0]   nwords_m1;
  logic          launch_err;
  logic [3:0]    launch_be;

  assign state_o = state_q;

  // Launch-time decode of the CSR view; only consumed in IDLE.
  always_comb begin
    sew_ok    = (vsew_i == VSEW_8) || (vsew_i == VSEW_16) || (vsew_i == VSEW_32);
    vlmax     = 32'd0;
    case (vsew_i)
      VSEW_8:  vlmax = 32'(VLEN / 8);
      VSEW_16: vlmax = 32'(VLEN / 16);
      VSEW_32: vlmax = 32'(VLEN / 32);
      default: vlmax = 32'd0;
    endcase
    nbytes     = {3'b000, vl_i} << vsew_i[1:0];
    nwords_m1  = ((nbytes + 11'd3) >> 2) - 11'd1;
    launch_err = !sew_ok || ({24'd0, vl_i} > vlmax) || (base_addr_i[1:0] != 2'b00);
    // Last-word mask: nbytes mod 4 selects 1..4 valid low bytes.
    case (nbytes[1:0])
      2'd1:    launch_be = 4'h1;
      2'd2:    launch_be = 4'h3;
      2'd3:    launch_be = 4'h7;
      default: launch_be = 4'hF;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      k_q          <= '0;
      last_k_q     <= '0;
      last_be_q    <= 4'h0;
      addr_q       <= 32'd0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      vrf_req_o    <= 1'b0;
      vrf_raddr_o  <= 5'd0;
      vrf_word_o   <= '0;
      data_req_o   <= 1'b0;
      data_addr_o  <= 32'd0;
      data_we_o    <= 1'b0;
      data_be_o    <= 4'h0;
      data_wdata_o <= 32'd0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_o      <= 1'b1;
            vrf_raddr_o <= vs3_i;
            vrf_word_o  <= '0;
            k_q         <= '0;
            addr_q      <= base_addr_i;
            last_k_q    <= KW'(nwords_m1);
            last_be_q   <= launch_be;
            if (launch_err || (vl_i == 8'd0)) begin
              state_q <= DONE;
              done_o  <= 1'b1;
              err_o   <= launch_err;
            end else begin
              state_q   <= READ;
              vrf_req_o <= 1'b1;
            end
          end
        end
        READ: begin
          if (vrf_rvalid_i) begin
            vrf_req_o    <= 1'b0;
            data_req_o   <= 1'b1;
            data_we_o    <= 1'b1;
            data_addr_o  <= addr_q;
            data_wdata_o <= vrf_rdata_i;
            data_be_o    <= (k_q == last_k_q) ? last_be_q : 4'hF;
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            data_we_o  <= 1'b0;
            state_q    <= RESP;
          end
        end
        RESP: begin
          // A bus error ends the transfer early; remaining words are dropped.
          if (data_rvalid_i) begin
            if (data_err_i || (k_q == last_k_q)) begin
              state_q <= DONE;
              done_o  <= 1'b1;
              err_o   <= data_err_i;
            end else begin
              k_q        <= k_q + KW'(1);
              vrf_word_o <= k_q + KW'(1);
              addr_q     <= addr_q + 32'd4;
              vrf_req_o  <= 1'b1;
              state_q    <= READ;
            end
          end
        end
        DONE: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vcve2_vstore_unit.sv
// Directed bench for vcve2_vstore_unit: VRF/bus responder, store scoreboard,
// done/err timing and reset behaviour.
module tb_vcve2_vstore_unit;

  localparam int VLEN = 128;
  localparam int NW   = VLEN / 32;
  localparam int KW   = (NW > 1) ? $clog2(NW) : 1;
  // Entry: {gnt_wait[76:69], err[68], addr[67:36], be[35:32], wdata[31:0]}
  localparam int W    = 77;

  logic          clk;
  logic          rst_ni;
  logic          start_i;
  logic [31:0]   base_addr_i;
  logic [2:0]    vsew_i;
  logic [7:0]    vl_i;
  logic [4:0]    vs3_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic          vrf_req_o;
  logic [4:0]    vrf_raddr_o;
  logic [KW-1:0] vrf_word_o;
  logic          vrf_rvalid_i;
  logic [31:0]   vrf_rdata_i;
  logic          data_req_o;
  logic [31:0]   data_addr_o;
  logic          data_we_o;
  logic [3:0]    data_be_o;
  logic [31:0]   data_wdata_o;
  logic          data_gnt_i;
  logic          data_rvalid_i;
  logic          data_err_i;
  logic [2:0]    state_o;

  logic          bus_rvalid;
  logic          stale_rvalid;
  assign data_rvalid_i = bus_rvalid | stale_rvalid;

  logic [VLEN-1:0] vregs [32];
  logic [W-1:0]    exp_q [$];
  int vectors;
  int miscompares;

  vcve2_vstore_unit #(.VLEN(VLEN)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
    .vsew_i(vsew_i), .vl_i(vl_i), .vs3_i(vs3_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .vrf_req_o(vrf_req_o), .vrf_raddr_o(vrf_raddr_o),
    .vrf_word_o(vrf_word_o), .vrf_rvalid_i(vrf_rvalid_i), .vrf_rdata_i(vrf_rdata_i),
    .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i), .state_o(state_o)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected stores for one operation, computed from the architectural rules.
  task automatic push_exp(input logic [31:0] base, input logic [2:0] vsew, input logic [7:0] vl,
                          input logic [4:0] vs3, input int err_word, input int gnt_word,
                          input int gnt_wait);
    int esz, nbytes, nwords, rem;
    logic [3:0] be;
    logic [W-1:0] e;
    esz    = 1 << vsew;
    nbytes = int'(vl) * esz;
    nwords = (nbytes + 3) / 4;
    for (int k = 0; k < nwords; k++) begin
      rem = (k == nwords - 1) ? nbytes - 4 * (nwords - 1) : 4;
      be  = 4'((1 << rem) - 1);
      e   = {8'((k == gnt_word) ? gnt_wait : 0), (k == err_word), base + 32'(4 * k), be,
             vregs[vs3][32 * k +: 32]};
      exp_q.push_back(e);
      if (k == err_word) break;
    end
  endtask

  // VRF and bus responder plus store scoreboard
  initial begin : bus_model
    logic [W-1:0] ent;
    logic hs, pend_err, req_prev;
    int wait_left;
    vrf_rvalid_i = 1'b0;
    vrf_rdata_i  = 32'd0;
    data_gnt_i   = 1'b0;
    bus_rvalid   = 1'b0;
    data_err_i   = 1'b0;
    pend_err     = 1'b0;
    req_prev     = 1'b0;
    wait_left    = 0;
    forever begin
      @(posedge clk);
      hs = rst_ni && data_req_o && data_gnt_i;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("extra_store", 64'(exp_q.size()), 64'd1);
          pend_err = 1'b0;
        end else begin
          ent = exp_q.pop_front();
          check("store_addr", data_addr_o, ent[67:36]);
          check("store_be", data_be_o, ent[35:32]);
          check("store_wdata", data_wdata_o, ent[31:0]);
          check("store_we", data_we_o, 1'b1);
          pend_err = ent[68];
        end
      end
      #1;
      bus_rvalid   = hs;
      data_err_i   = hs && pend_err;
      vrf_rvalid_i = vrf_req_o;
      vrf_rdata_i  = vregs[vrf_raddr_o][32 * int'(vrf_word_o) +: 32];
      if (data_req_o) begin
        if (!req_prev) wait_left = (exp_q.size() > 0) ? int'(exp_q[0][76:69]) : 0;
        if (wait_left > 0) begin
          data_gnt_i = 1'b0;
          wait_left--;
          if (exp_q.size() > 0) begin
            check("hold_addr", data_addr_o, exp_q[0][67:36]);
            check("hold_wdata", data_wdata_o, exp_q[0][31:0]);
          end
        end else begin
          data_gnt_i = 1'b1;
        end
      end else begin
        data_gnt_i = 1'b0;
      end
      req_prev = data_req_o;
    end
  end

  // Drives one start and follows the unit to done; cycle 0 is the start cycle.
  task automatic run_op(input logic [31:0] base, input logic [2:0] vsew, input logic [7:0] vl,
                        input logic [4:0] vs3, output int done_cyc, output logic err_seen,
                        output int vrf_cyc, output int req_cyc, output logic busy1);
    int cyc;
    done_cyc = -1;
    err_seen = 1'b0;
    vrf_cyc  = 0;
    req_cyc  = 0;
    @(posedge clk); #1;
    start_i     = 1'b1;
    base_addr_i = base;
    vsew_i      = vsew;
    vl_i        = vl;
    vs3_i       = vs3;
    @(posedge clk); #1;
    start_i     = 1'b0;
    base_addr_i = $urandom;
    vsew_i      = 3'($urandom_range(0, 7));
    vl_i        = 8'($urandom_range(0, 255));
    vs3_i       = 5'($urandom_range(0, 31));
    busy1       = busy_o;
    cyc         = 1;
    while (cyc < 300 && done_cyc < 0) begin
      start_i = (cyc == 2);
      if (vrf_req_o) vrf_cyc++;
      if (data_req_o) req_cyc++;
      if (done_o) begin
        done_cyc = cyc;
        err_seen = err_o;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    check({tag, "_busy_drop"}, busy_o, 1'b0);
    check({tag, "_done_drop"}, done_o, 1'b0);
  endtask

  task automatic zero_check(input string tag);
    check({tag, "_ctl"}, {busy_o, done_o, err_o, vrf_req_o, data_req_o, data_we_o}, 6'd0);
    check({tag, "_vrf"}, {vrf_raddr_o, vrf_word_o}, '0);
    check({tag, "_addr"}, data_addr_o, 32'd0);
    check({tag, "_be"}, data_be_o, 4'd0);
    check({tag, "_wdata"}, data_wdata_o, 32'd0);
  endtask

  initial begin : main
    int dc, vc, rc, n;
    logic es, b1;
    vectors      = 0;
    miscompares  = 0;
    rst_ni       = 1'b0;
    start_i      = 1'b0;
    base_addr_i  = 32'd0;
    vsew_i       = 3'd0;
    vl_i         = 8'd0;
    vs3_i        = 5'd0;
    stale_rvalid = 1'b0;
    for (int r = 0; r < 32; r++)
      for (int w = 0; w < NW; w++) vregs[r][32 * w +: 32] = $urandom;

    repeat (2) @(posedge clk);
    #1;
    zero_check("reset");
    rst_ni = 1'b1;

    // e8, vl=6: two stores, last with two bytes
    push_exp(32'h1000, 3'd0, 8'd6, 5'd2, -1, -1, 0);
    run_op(32'h1000, 3'd0, 8'd6, 5'd2, dc, es, vc, rc, b1);
    check("e8_busy_c1", b1, 1'b1);
    check("e8_done_cycle", 64'(dc), 64'd7);
    check("e8_err", es, 1'b0);
    check("e8_vrf_cycles", 64'(vc), 64'd2);
    check("e8_req_cycles", 64'(rc), 64'd2);
    check("e8_q_empty", 64'(exp_q.size()), 64'd0);
    idle_check("e8");

    // e32, vl=4, word 1 grant delayed 3 cycles
    push_exp(32'h1000, 3'd2, 8'd4, 5'd4, -1, 1, 3);
    run_op(32'h1000, 3'd2, 8'd4, 5'd4, dc, es, vc, rc, b1);
    check("gw_done_cycle", 64'(dc), 64'd16);
    check("gw_err", es, 1'b0);
    check("gw_vrf_cycles", 64'(vc), 64'd4);
    check("gw_req_cycles", 64'(rc), 64'd7);
    check("gw_q_empty", 64'(exp_q.size()), 64'd0);
    idle_check("gw");

    // Launch errors: vl over VLMAX, misaligned base, reserved vsew
    run_op(32'h1000, 3'd2, 8'd5, 5'd1, dc, es, vc, rc, b1);
    check("vlmax_done_cycle", 64'(dc), 64'd1);
    check("vlmax_err", es, 1'b1);
    check("vlmax_no_access", 64'(vc + rc), 64'd0);
    idle_check("vlmax");
    run_op(32'h1002, 3'd0, 8'd4, 5'd1, dc, es, vc, rc, b1);
    check("misalign_busy_c1", b1, 1'b1);
    check("misalign_done_cycle", 64'(dc), 64'd1);
    check("misalign_err", es, 1'b1);
    check("misalign_no_access", 64'(vc + rc), 64'd0);
    idle_check("misalign");
    run_op(32'h1000, 3'b111, 8'd2, 5'd1, dc, es, vc, rc, b1);
    check("badsew_done_cycle", 64'(dc), 64'd1);
    check("badsew_err", es, 1'b1);
    check("badsew_no_access", 64'(vc + rc), 64'd0);
    idle_check("badsew");

    // vl=0 completes cleanly with no traffic
    run_op(32'h1000, 3'd0, 8'd0, 5'd1, dc, es, vc, rc, b1);
    check("vl0_done_cycle", 64'(dc), 64'd1);
    check("vl0_err", es, 1'b0);
    check("vl0_no_access", 64'(vc + rc), 64'd0);
    idle_check("vl0");

    // e16, vl=8, bus error on word 1, then a normal store
    push_exp(32'h1100, 3'd1, 8'd8, 5'd3, 1, -1, 0);
    run_op(32'h1100, 3'd1, 8'd8, 5'd3, dc, es, vc, rc, b1);
    check("berr_done_cycle", 64'(dc), 64'd7);
    check("berr_err", es, 1'b1);
    check("berr_req_cycles", 64'(rc), 64'd2);
    check("berr_q_empty", 64'(exp_q.size()), 64'd0);
    idle_check("berr");
    push_exp(32'h2000, 3'd1, 8'd3, 5'd5, -1, -1, 0);
    run_op(32'h2000, 3'd1, 8'd3, 5'd5, dc, es, vc, rc, b1);
    check("after_err_done_cycle", 64'(dc), 64'd7);
    check("after_err_err", es, 1'b0);
    check("after_err_q_empty", 64'(exp_q.size()), 64'd0);
    idle_check("after_err");

    // Reset while word 2 waits for its grant
    push_exp(32'h3000, 3'd0, 8'd16, 5'd7, -1, 2, 200);
    @(posedge clk); #1;
    start_i     = 1'b1;
    base_addr_i = 32'h3000;
    vsew_i      = 3'd0;
    vl_i        = 8'd16;
    vs3_i       = 5'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 0;
    while (!(data_req_o && data_addr_o == 32'h3008) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_reached_word2", {data_req_o, data_addr_o}, {1'b1, 32'h3008});
    #2;
    rst_ni = 1'b0;
    #1;
    zero_check("midrst");
    exp_q.delete();
    @(posedge clk); #1;
    rst_ni       = 1'b1;
    stale_rvalid = 1'b1;
    @(posedge clk); #1;
    stale_rvalid = 1'b0;
    check("stale_rvalid_idle", {busy_o, done_o, err_o, vrf_req_o, data_req_o}, 5'd0);
    @(posedge clk); #1;
    check("stale_rvalid_idle2", {busy_o, done_o, vrf_req_o, data_req_o}, 4'd0);

    // Address wrap-around, zero-wait bus
    push_exp(32'hFFFF_FFF8, 3'd2, 8'd4, 5'd9, -1, -1, 0);
    run_op(32'hFFFF_FFF8, 3'd2, 8'd4, 5'd9, dc, es, vc, rc, b1);
    check("wrap_done_cycle", 64'(dc), 64'd13);
    check("wrap_err", es, 1'b0);
    check("wrap_q_empty", 64'(exp_q.size()), 64'd0);
    idle_check("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
